// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // One extra bit so WIDTH-1 is always representable without wrap at WIDTH=2^k.
  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational full adder built from two half-adder cells and an OR.
module serial_half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;
endmodule

module serial_fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  logic w_s1;
  logic w_c1;
  logic w_c2;

  serial_half_adder u_ha0 (.i_a(x),    .i_b(y),  .o_s(w_s1), .o_c(w_c1));
  serial_half_adder u_ha1 (.i_a(w_s1), .i_b(ci), .o_s(s),    .o_c(w_c2));

  assign co = w_c1 | w_c2;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: accepts two operands, adds LSB-first over WIDTH cycles.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = cnt_w(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic [CW-1:0]    r_count;
  logic             r_carry;
  logic             r_alive;
  logic             w_s;
  logic             w_co;
  logic             w_accept;
  logic             w_last;

  serial_fa_cell u_fa (
    .x  (r_a_sh[0]),
    .y  (r_b_sh[0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  // r_alive keeps in_ready low until the first edge after reset release.
  assign in_ready  = r_alive && (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum_sh;
  assign cout      = r_carry;
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_count == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_alive <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_alive <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = SHIFT;
      SHIFT:   if (w_last) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_count  <= '0;
      r_carry  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= cin;
            r_count <= '0;
          end
        end
        SHIFT: begin
          r_carry  <= w_co;
          r_sum_sh <= {w_s, r_sum_sh[WIDTH-1:1]};
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_count  <= r_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed checks of serial_adder at WIDTH=8 plus exhaustive WIDTH=4 sweep.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8;
  logic [7:0] a8, b8, sum8;

  logic       in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4;
  logic [3:0] a4, b4, sum4;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int n = 0;
    while (in_ready8 !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("start8_ready", {31'd0, in_ready8}, 32'd1);
    a8 = a; b8 = b; cin8 = c; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
  endtask

  task automatic wait_out8(output int lat);
    lat = 0;
    while (out_valid8 !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic c, input logic [7:0] es, input logic ec);
    int lat;
    start8(a, b, c);
    wait_out8(lat);
    chk({tag, "_lat"},  lat, 32'd8);
    chk({tag, "_sum"},  {24'd0, sum8}, {24'd0, es});
    chk({tag, "_cout"}, {31'd0, cout8}, {31'd0, ec});
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    logic [4:0] ref4;

    rst_n = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; out_ready8 = 1'b1;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; out_ready4 = 1'b1;
    #1;
    chk("rst_in_ready",  {31'd0, in_ready8},  32'd0);
    chk("rst_out_valid", {31'd0, out_valid8}, 32'd0);
    chk("rst_sum",       {24'd0, sum8},       32'd0);
    chk("rst_cout",      {31'd0, cout8},      32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready",  {31'd0, in_ready8},  32'd1);
    chk("post_rst_out_valid", {31'd0, out_valid8}, 32'd0);

    op8("add0f01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
    op8("addff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    op8("addffff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // Backpressure: hold result 5 cycles while a stray request is offered.
    out_ready8 = 1'b0;
    start8(8'h3C, 8'h0F, 1'b0);
    wait_out8(lat);
    chk("bp_lat", lat, 32'd8);
    a8 = 8'h55; b8 = 8'h55; in_valid8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", {31'd0, out_valid8}, 32'd1);
      chk("bp_sum",       {24'd0, sum8},       32'h4B);
      chk("bp_cout",      {31'd0, cout8},      32'd0);
      chk("bp_in_ready",  {31'd0, in_ready8},  32'd0);
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    chk("bp_drain_out_valid", {31'd0, out_valid8}, 32'd0);
    chk("bp_drain_in_ready",  {31'd0, in_ready8},  32'd1);
    op8("bp_next", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

    // Busy-ignore: new operands offered during SHIFT must not disturb the sum.
    start8(8'h12, 8'h34, 1'b0);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b0; in_valid8 = 1'b1;
    chk("busy_in_ready", {31'd0, in_ready8}, 32'd0);
    wait_out8(lat);
    chk("busy_lat",      lat, 32'd8);
    chk("busy_sum",      {24'd0, sum8},      32'h46);
    chk("busy_cout",     {31'd0, cout8},     32'd0);
    chk("busy_done_rdy", {31'd0, in_ready8}, 32'd0);
    @(posedge clk); #1;
    chk("busy_drain_rdy", {31'd0, in_ready8}, 32'd1);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    chk("busy_accept2_rdy", {31'd0, in_ready8}, 32'd0);
    wait_out8(lat);
    chk("busy2_lat",  lat, 32'd8);
    chk("busy2_sum",  {24'd0, sum8},  32'hFE);
    chk("busy2_cout", {31'd0, cout8}, 32'd1);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of an operation.
    start8(8'hAA, 8'h55, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready",  {31'd0, in_ready8},  32'd0);
    chk("mid_rst_out_valid", {31'd0, out_valid8}, 32'd0);
    chk("mid_rst_sum",       {24'd0, sum8},       32'd0);
    chk("mid_rst_cout",      {31'd0, cout8},      32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rel_in_ready0", {31'd0, in_ready8}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("mid_rel_no_valid", {31'd0, out_valid8}, 32'd0);
    end
    chk("mid_rel_in_ready1", {31'd0, in_ready8}, 32'd1);

    // Exhaustive WIDTH=4 sweep against a reference sum.
    for (int unsigned k = 0; k < 512; k++) begin
      int n = 0;
      a4 = k[3:0]; b4 = k[7:4]; cin4 = k[8];
      ref4 = {1'b0, a4} + {1'b0, b4} + {4'd0, cin4};
      while (in_ready4 !== 1'b1 && n < 20) begin
        @(posedge clk); #1; n++;
      end
      in_valid4 = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      lat = 0;
      while (out_valid4 !== 1'b1 && lat < 40) begin
        @(posedge clk); #1; lat++;
      end
      chk("w4_lat",  lat, 32'd4);
      chk("w4_sum",  {28'd0, sum4},  {28'd0, ref4[3:0]});
      chk("w4_cout", {31'd0, cout4}, {31'd0, ref4[4]});
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
